// File: rtl/fft_addr_gen_if.sv
// Sequencer-side bundle for the radix-2 DIT FFT address generator:
// start/hold control, stage strobes, operand/twiddle read addresses, write-back addresses.
interface fft_addr_gen_if #(
   parameter int LOG2N = 4,
   parameter int STG_W = $clog2(LOG2N)
);
   logic             start;
   logic             hold;
   logic             busy;
   logic             done;
   logic             stage_en;
   logic [STG_W-1:0] stage;
   logic             rd_valid;
   logic [LOG2N-1:0] rd_addr_a;
   logic [LOG2N-1:0] rd_addr_b;
   logic [LOG2N-2:0] tw_addr;
   logic             wr_valid;
   logic [LOG2N-1:0] wr_addr_a;
   logic [LOG2N-1:0] wr_addr_b;

   modport master (
      input  start, hold,
      output busy, done, stage_en, stage,
      output rd_valid, rd_addr_a, rd_addr_b, tw_addr,
      output wr_valid, wr_addr_a, wr_addr_b
   );

   modport slave (
      output start, hold,
      input  busy, done, stage_en, stage,
      input  rd_valid, rd_addr_a, rd_addr_b, tw_addr,
      input  wr_valid, wr_addr_a, wr_addr_b
   );
endinterface

// File: rtl/fft_addr_gen.sv
// In-place radix-2 DIT FFT sequencer: one butterfly per cycle, stage drain between
// stages, and a BFLY_LAT-deep write pipe that replays read addresses as write-back addresses.
module fft_addr_gen #(
   parameter int LOG2N    = 4,
   parameter int BFLY_LAT = 3,
   parameter int STG_W    = $clog2(LOG2N)
) (
   input  logic          clk,
   input  logic          rst,
   fft_addr_gen_if.master bus
);
   localparam int JW = LOG2N - 1;
   localparam int DW = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;
   localparam logic [JW-1:0]    J_LAST = '1;
   localparam logic [STG_W-1:0] S_LAST = STG_W'(LOG2N - 1);
   localparam logic [DW-1:0]    D_LAST = DW'(BFLY_LAT - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t           state, state_n;
   logic [JW-1:0]    j, j_n;
   logic [STG_W-1:0] s, s_n;
   logic [DW-1:0]    d, d_n;
   logic             frz;
   logic             active;

   logic [LOG2N-1:0] jx, span, pos, grp, a_dec;
   logic [JW-1:0]    tw_dec;
   logic [STG_W-1:0] tsh;

   logic [BFLY_LAT-1:0] pv;
   logic [LOG2N-1:0]    pa [BFLY_LAT];
   logic [LOG2N-1:0]    pb [BFLY_LAT];

   always_comb begin
      frz    = bus.hold && (state != IDLE);
      active = (state != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         j     <= '0;
         s     <= '0;
         d     <= '0;
      end else begin
         state <= state_n;
         j     <= j_n;
         s     <= s_n;
         d     <= d_n;
      end
   end

   always_comb begin
      state_n      = state;
      j_n          = j;
      s_n          = s;
      d_n          = d;
      bus.rd_valid = 1'b0;
      bus.stage_en = 1'b0;
      bus.done     = 1'b0;
      bus.busy     = (state == RUN) || (state == DRAIN);
      if (!frz) begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state_n = RUN;
                  j_n     = '0;
                  s_n     = '0;
               end
            end
            RUN: begin
               bus.rd_valid = 1'b1;
               j_n          = j + JW'(1);
               if (j == J_LAST) begin
                  state_n = DRAIN;
                  d_n     = '0;
               end
            end
            DRAIN: begin
               d_n = d + DW'(1);
               // Last write of the stage is on wr_* now, so the next stage may start reading.
               if (d == D_LAST) begin
                  if (s == S_LAST) begin
                     state_n = DONE;
                  end else begin
                     bus.stage_en = 1'b1;
                     s_n          = s + STG_W'(1);
                     j_n          = '0;
                     state_n      = RUN;
                  end
               end
            end
            DONE: begin
               bus.done = 1'b1;
               s_n      = '0;
               state_n  = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // Insert a zero at bit s of j to get the upper operand; twiddle scales pos to N/2 steps.
   always_comb begin
      jx            = {1'b0, j};
      span          = LOG2N'(1) << s;
      pos           = jx & (span - LOG2N'(1));
      grp           = jx >> s;
      a_dec         = ((grp << s) << 1) | pos;
      tsh           = S_LAST - s;
      tw_dec        = JW'(pos << tsh);
      bus.rd_addr_a = active ? a_dec : '0;
      bus.rd_addr_b = active ? (a_dec + span) : '0;
      bus.tw_addr   = active ? tw_dec : '0;
      bus.stage     = s;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pv <= '0;
         for (int unsigned i = 0; i < BFLY_LAT; i++) begin
            pa[i] <= '0;
            pb[i] <= '0;
         end
      end else if (!frz) begin
         pv[0] <= bus.rd_valid;
         pa[0] <= bus.rd_addr_a;
         pb[0] <= bus.rd_addr_b;
         for (int unsigned i = 1; i < BFLY_LAT; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
            pb[i] <= pb[i-1];
         end
      end
   end

   always_comb begin
      bus.wr_valid  = pv[BFLY_LAT-1] && !frz;
      bus.wr_addr_a = pa[BFLY_LAT-1];
      bus.wr_addr_b = pb[BFLY_LAT-1];
   end
endmodule

// File: tb/tb_fft_addr_gen.sv
// Directed, table-driven bench for fft_addr_gen at LOG2N=4, BFLY_LAT=3.
module tb_fft_addr_gen;
   localparam int LOG2N = 4;
   localparam int LAT   = 3;
   localparam int TBL   = 50;

   logic clk;
   logic rst;
   int   n_chk = 0;
   int   n_err = 0;

   fft_addr_gen_if #(.LOG2N(LOG2N), .STG_W(2)) bus ();

   fft_addr_gen #(.LOG2N(LOG2N), .BFLY_LAT(LAT), .STG_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      bit rv;
      bit se;
      bit dn;
      bit bz;
      int stg;
   } vec_t;

   typedef struct {
      int s;
      int j;
      int a;
      int b;
      int tw;
   } avec_t;

   vec_t  tbl [TBL];
   avec_t av  [8];

   int t_hd [64], t_rv [64], t_se [64], t_dn [64], t_bz [64], t_st [64];
   int t_ra [64], t_rb [64], t_tw [64], t_wv [64], t_wa [64], t_wb [64];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // m-th issued butterfly: enumerate addresses with bit s clear in ascending order.
   task automatic amodel(input int m, output int a, output int b, output int tw);
      int s, jj, cnt;
      s   = m / 8;
      jj  = m % 8;
      cnt = -1;
      a   = 0;
      for (int x = 0; x < 16; x++) begin
         if (((x >> s) & 1) == 0) begin
            cnt++;
            if (cnt == jj) begin
               a = x;
               break;
            end
         end
      end
      b  = a + (1 << s);
      tw = (a % (1 << s)) * (8 >> s);
   endtask

   task automatic capture(input int ncyc, input int st0, input int st1, input int st2,
                          input int h1s, input int h1l, input int h2s, input int h2l);
      for (int c = 0; c < ncyc; c++) begin
         bus.start = (c == st0) || (c == st1) || (c == st2);
         bus.hold  = (c >= h1s && c < h1s + h1l) || (c >= h2s && c < h2s + h2l);
         #1;
         t_hd[c] = int'(bus.hold);
         t_rv[c] = int'(bus.rd_valid);
         t_se[c] = int'(bus.stage_en);
         t_dn[c] = int'(bus.done);
         t_bz[c] = int'(bus.busy);
         t_st[c] = int'(bus.stage);
         t_ra[c] = int'(bus.rd_addr_a);
         t_rb[c] = int'(bus.rd_addr_b);
         t_tw[c] = int'(bus.tw_addr);
         t_wv[c] = int'(bus.wr_valid);
         t_wa[c] = int'(bus.wr_addr_a);
         t_wb[c] = int'(bus.wr_addr_b);
         @(posedge clk);
         #1;
      end
      bus.start = 1'b0;
      bus.hold  = 1'b0;
   endtask

   task automatic check_run(input int ncyc);
      int k, nrd, nwr, a, b, tw;
      int wcnt [4];
      int h_rv [64], h_ra [64], h_rb [64];
      k = 0; nrd = 0; nwr = 0;
      for (int i = 0; i < 4; i++) wcnt[i] = 0;
      for (int c = 0; c < ncyc; c++) begin
         if (k >= TBL) break;
         chk("busy", t_bz[c], int'(tbl[k].bz));
         chk("stage", t_st[c], tbl[k].stg);
         if (t_hd[c] != 0) begin
            chk("hold_rd_valid", t_rv[c], 0);
            chk("hold_wr_valid", t_wv[c], 0);
            chk("hold_stage_en", t_se[c], 0);
            chk("hold_done", t_dn[c], 0);
            if (tbl[k].rv) begin
               amodel(nrd, a, b, tw);
               chk("hold_rd_addr_a", t_ra[c], a);
               chk("hold_rd_addr_b", t_rb[c], b);
            end
         end else begin
            chk("rd_valid", t_rv[c], int'(tbl[k].rv));
            chk("stage_en", t_se[c], int'(tbl[k].se));
            chk("done", t_dn[c], int'(tbl[k].dn));
            if (t_rv[c] != 0) begin
               amodel(nrd, a, b, tw);
               chk("rd_addr_a", t_ra[c], a);
               chk("rd_addr_b", t_rb[c], b);
               chk("tw_addr", t_tw[c], tw);
               nrd++;
            end
            if (k >= LAT) begin
               chk("wr_valid", t_wv[c], h_rv[k-LAT]);
               if (h_rv[k-LAT] != 0) begin
                  chk("wr_addr_a", t_wa[c], h_ra[k-LAT]);
                  chk("wr_addr_b", t_wb[c], h_rb[k-LAT]);
               end
            end else begin
               chk("wr_valid_early", t_wv[c], 0);
            end
            if (t_wv[c] != 0) begin
               nwr++;
               if (t_st[c] >= 0 && t_st[c] < 4) wcnt[t_st[c]]++;
            end
            h_rv[k] = t_rv[c];
            h_ra[k] = t_ra[c];
            h_rb[k] = t_rb[c];
            k++;
         end
      end
      chk("issue_count", nrd, 32);
      chk("write_count", nwr, 32);
      for (int i = 0; i < 4; i++) chk("writes_per_stage", wcnt[i], 8);
   endtask

   initial begin
      // Expected per-cycle strobes for a run started in cycle 0 with no stalls.
      for (int c = 0; c < TBL; c++) begin
         tbl[c].rv  = (c >= 1 && c <= 8) || (c >= 12 && c <= 19) ||
                      (c >= 23 && c <= 30) || (c >= 34 && c <= 41);
         tbl[c].se  = (c == 11) || (c == 22) || (c == 33);
         tbl[c].dn  = (c == 45);
         tbl[c].bz  = (c >= 1 && c <= 44);
         tbl[c].stg = (c <= 11) ? 0 : (c <= 22) ? 1 : (c <= 33) ? 2 : (c <= 45) ? 3 : 0;
      end
      av[0] = '{s: 0, j: 3, a: 6,  b: 7,  tw: 0};
      av[1] = '{s: 1, j: 3, a: 5,  b: 7,  tw: 4};
      av[2] = '{s: 2, j: 5, a: 9,  b: 13, tw: 2};
      av[3] = '{s: 3, j: 5, a: 5,  b: 13, tw: 5};
      av[4] = '{s: 0, j: 0, a: 0,  b: 1,  tw: 0};
      av[5] = '{s: 3, j: 7, a: 7,  b: 15, tw: 7};
      av[6] = '{s: 2, j: 0, a: 0,  b: 4,  tw: 0};
      av[7] = '{s: 1, j: 6, a: 12, b: 14, tw: 0};

      bus.start = 1'b0;
      bus.hold  = 1'b0;
      rst       = 1'b0;
      #2;
      chk("reset_busy", int'(bus.busy), 0);
      chk("reset_done", int'(bus.done), 0);
      chk("reset_rd_valid", int'(bus.rd_valid), 0);
      chk("reset_rd_addr_b", int'(bus.rd_addr_b), 0);
      chk("reset_wr_valid", int'(bus.wr_valid), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Plain run, plus the fixed address vectors looked up at their issue cycles.
      capture(50, 0, -1, -1, -1, 0, -1, 0);
      check_run(50);
      for (int i = 0; i < 8; i++) begin
         int c;
         c = 1 + 11 * av[i].s + av[i].j;
         chk("vec_rd_valid", t_rv[c], 1);
         chk("vec_rd_addr_a", t_ra[c], av[i].a);
         chk("vec_rd_addr_b", t_rb[c], av[i].b);
         chk("vec_tw_addr", t_tw[c], av[i].tw);
      end

      // Stalls: 5 cycles in stage-1 RUN, 2 cycles in stage-2 DRAIN; done moves to 52.
      capture(57, 0, -1, -1, 14, 5, 37, 2);
      check_run(57);
      chk("hold_done_cycle", t_dn[52], 1);
      chk("hold_done_nominal", t_dn[45], 0);

      // start during RUN and during DONE is ignored; the following IDLE start runs again.
      capture(50, 0, 5, 45, -1, 0, -1, 0);
      check_run(50);
      capture(50, 0, -1, -1, -1, 0, -1, 0);
      check_run(50);

      // Asynchronous reset in the middle of stage-2 DRAIN.
      capture(32, 0, -1, -1, -1, 0, -1, 0);
      #1;
      chk("pre_rst_busy", int'(bus.busy), 1);
      chk("pre_rst_stage", int'(bus.stage), 2);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_stage_en", int'(bus.stage_en), 0);
      chk("rst_stage", int'(bus.stage), 0);
      chk("rst_rd_valid", int'(bus.rd_valid), 0);
      chk("rst_rd_addr_a", int'(bus.rd_addr_a), 0);
      chk("rst_rd_addr_b", int'(bus.rd_addr_b), 0);
      chk("rst_tw_addr", int'(bus.tw_addr), 0);
      chk("rst_wr_valid", int'(bus.wr_valid), 0);
      chk("rst_wr_addr_a", int'(bus.wr_addr_a), 0);
      chk("rst_wr_addr_b", int'(bus.wr_addr_b), 0);
      @(posedge clk);
      @(posedge clk);
      #4;
      rst = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         #1;
         chk("post_rst_done", int'(bus.done), 0);
         chk("post_rst_busy", int'(bus.busy), 0);
         chk("post_rst_stage_en", int'(bus.stage_en), 0);
      end
      capture(50, 0, -1, -1, -1, 0, -1, 0);
      check_run(50);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
